// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for a 5-stage in-order core.
//               Drives enable/clear of the IF_ID, ID_EX, EX_MEM and MEM_WB
//               stage registers and the PC enable, generates EX-stage operand
//               forwarding selects, inserts a single bubble on load-use,
//               flushes wrong-path instructions on a taken branch resolved in
//               EX, and halts on a halt-type syscall in WB until a rising edge
//               of go is seen.
// Ports       : clk, rst_n               clock, async active-low reset
//               id_rs/id_rt/id_uses_*    ID-stage source operands
//               ex_rs/ex_rt/ex_*         EX-stage sources and destination
//               mem_*/wb_*               MEM/WB destination write info
//               branch_taken, wb_halt,go control events
//               pc_en, *_en, *_clr       stage register controls
//               fwd_a, fwd_b             00 regfile, 01 EX_MEM, 10 MEM_WB
//               halted                   1 while halted
//               stall_cnt, flush_cnt     saturating event counters
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic             ex_regwrite,
   input  logic             ex_memtoreg,
   input  logic [4:0]       ex_write_reg,
   input  logic             mem_regwrite,
   input  logic [4:0]       mem_write_reg,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_write_reg,
   input  logic             branch_taken,
   input  logic             wb_halt,
   input  logic             go,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_clr,
   output logic             idex_en,
   output logic             idex_clr,
   output logic             exmem_en,
   output logic             exmem_clr,
   output logic             memwb_en,
   output logic             memwb_clr,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALT   = 2'd1,
      ST_RESUME = 2'd2
   } state_t;

   localparam logic [1:0] c_FWD_RF  = 2'b00;
   localparam logic [1:0] c_FWD_MEM = 2'b01;
   localparam logic [1:0] c_FWD_WB  = 2'b10;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_go_q;
   logic             w_go_rise;
   logic             w_load_use;
   logic             w_stall_inc;
   logic             w_flush_inc;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // ------------------------------------------------------------------------
   // Forwarding: the youngest producer (MEM) wins over WB; $0 is hardwired
   // zero in the register file, so it is never forwarded.
   // ------------------------------------------------------------------------
   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      logic [1:0] sel;
      sel = c_FWD_RF;
      if (mem_regwrite && (mem_write_reg != 5'd0) && (mem_write_reg == src))
         sel = c_FWD_MEM;
      else if (wb_regwrite && (wb_write_reg != 5'd0) && (wb_write_reg == src))
         sel = c_FWD_WB;
      return sel;
   endfunction

   assign fwd_a = fwd_sel(ex_rs);
   assign fwd_b = fwd_sel(ex_rt);

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   assign w_go_rise  = go & ~r_go_q;

   assign w_load_use = ex_memtoreg && ex_regwrite && (ex_write_reg != 5'd0) &&
                       ((id_uses_rs && (id_rs == ex_write_reg)) ||
                        (id_uses_rt && (id_rt == ex_write_reg)));

   // ------------------------------------------------------------------------
   // Stage control and next-state decode
   // ------------------------------------------------------------------------
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_clr    = 1'b0;
      idex_clr    = 1'b0;
      exmem_clr   = 1'b0;
      memwb_clr   = 1'b0;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
      w_state_nxt = r_state;

      case (r_state)
         ST_HALT: begin
            // Freeze everything; only a fresh go edge leaves this state.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            if (w_go_rise)
               w_state_nxt = ST_RESUME;
         end

         default: begin
            // RUN and RESUME share the branch / load-use rules.
            w_state_nxt = ST_RUN;
            if ((r_state == ST_RUN) && wb_halt) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_en    = 1'b0;
               w_state_nxt = ST_HALT;
            end else begin
               // The halting syscall still sits in MEM_WB when we resume;
               // clearing it prevents a second halt.
               if (r_state == ST_RESUME)
                  memwb_clr = 1'b1;

               if (branch_taken) begin
                  // Wrong-path instructions in IF_ID and ID_EX are squashed;
                  // any load-use against them is moot.
                  ifid_clr    = 1'b1;
                  idex_clr    = 1'b1;
                  w_flush_inc = 1'b1;
               end else if (w_load_use) begin
                  // Hold PC and IF_ID, inject a bubble into ID_EX.
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_clr    = 1'b1;
                  w_stall_inc = 1'b1;
               end
            end
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, go edge detector and saturating statistics
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_go_q      <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_go_q  <= go;
         if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}}))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign halted    = (r_state == ST_HALT);
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed testbench for hazard_ctrl (CNT_W=2). Each vector
//               drives the inputs and queues its hand-computed expected
//               outputs; an independent monitor pops and compares them on
//               the falling clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int CNT_W = 2;

   logic             clk;
   logic             rst_n;
   logic [4:0]       id_rs, id_rt, ex_rs, ex_rt;
   logic             id_uses_rs, id_uses_rt;
   logic             ex_regwrite, ex_memtoreg;
   logic [4:0]       ex_write_reg, mem_write_reg, wb_write_reg;
   logic             mem_regwrite, wb_regwrite;
   logic             branch_taken, wb_halt, go;
   logic             pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
   logic             exmem_en, exmem_clr, memwb_en, memwb_clr;
   logic [1:0]       fwd_a, fwd_b;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.CNT_W(CNT_W)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .ex_regwrite  (ex_regwrite),
      .ex_memtoreg  (ex_memtoreg),
      .ex_write_reg (ex_write_reg),
      .mem_regwrite (mem_regwrite),
      .mem_write_reg(mem_write_reg),
      .wb_regwrite  (wb_regwrite),
      .wb_write_reg (wb_write_reg),
      .branch_taken (branch_taken),
      .wb_halt      (wb_halt),
      .go           (go),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .ifid_clr     (ifid_clr),
      .idex_en      (idex_en),
      .idex_clr     (idex_clr),
      .exmem_en     (exmem_en),
      .exmem_clr    (exmem_clr),
      .memwb_en     (memwb_en),
      .memwb_clr    (memwb_clr),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .halted       (halted),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   // Clock starts high so the first edge after stimulus is a falling edge.
   initial clk = 1'b1;
   always #5 clk = ~clk;

   // {en: pc,ifid,idex,exmem,memwb}{clr: ifid,idex,exmem,memwb}{fa}{fb}{h}{s}{f}
   typedef struct {
      string       name;
      logic [17:0] vec;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Monitor: compares DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      if (q_exp.size() > 0) begin
         exp_t        e;
         logic [17:0] act;
         e   = q_exp.pop_front();
         act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_clr, idex_clr, exmem_clr, memwb_clr,
                fwd_a, fwd_b, halted, stall_cnt, flush_cnt};
         n_checks++;
         if (act === e.vec)
            n_pass++;
         else
            $display("FAIL %s: got %b expected %b (en5 clr4 fa2 fb2 h s2 f2)",
                     e.name, act, e.vec);
      end
   end

   task automatic step(input string nm, input logic [4:0] en, input logic [3:0] clr,
                       input logic [1:0] fa, input logic [1:0] fb, input logic h,
                       input logic [1:0] s, input logic [1:0] f);
      exp_t e;
      e.name = nm;
      e.vec  = {en, clr, fa, fb, h, s, f};
      q_exp.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      ex_rs = 0; ex_rt = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_write_reg = 0;
      mem_regwrite = 0; mem_write_reg = 0; wb_regwrite = 0; wb_write_reg = 0;
      branch_taken = 0; wb_halt = 0; go = 0;
   endtask

   task automatic load_use_rs8();
      ex_memtoreg = 1; ex_regwrite = 1; ex_write_reg = 5'd8;
      id_rs = 5'd8; id_uses_rs = 1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      step("reset_idle",     5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0);
      rst_n = 1'b1;
      step("run_idle",       5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0);

      load_use_rs8();
      step("loaduse_rs",     5'b00111, 4'b0100, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0);
      idle();
      step("after_stall",    5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd1, 2'd0);
      ex_memtoreg = 1; ex_regwrite = 1; ex_write_reg = 5'd8;
      id_rs = 5'd8; id_uses_rs = 0; id_rt = 5'd8; id_uses_rt = 1;
      step("loaduse_rt",     5'b00111, 4'b0100, 2'b00, 2'b00, 1'b0, 2'd1, 2'd0);
      idle();
      ex_memtoreg = 1; ex_regwrite = 1; ex_write_reg = 5'd0;
      id_rs = 5'd0; id_uses_rs = 1;
      step("loaduse_reg0",   5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd2, 2'd0);
      idle();
      load_use_rs8();
      branch_taken = 1;
      step("branch_wins",    5'b11111, 4'b1100, 2'b00, 2'b00, 1'b0, 2'd2, 2'd0);
      idle();
      step("after_flush",    5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd2, 2'd1);

      mem_regwrite = 1; mem_write_reg = 5'd5; wb_regwrite = 1; wb_write_reg = 5'd5;
      ex_rs = 5'd5; ex_rt = 5'd3;
      step("fwd_mem_beats_wb", 5'b11111, 4'b0000, 2'b01, 2'b00, 1'b0, 2'd2, 2'd1);
      mem_write_reg = 5'd0; wb_write_reg = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
      step("fwd_reg0",       5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd2, 2'd1);
      mem_regwrite = 0; mem_write_reg = 5'd5; wb_write_reg = 5'd5;
      ex_rs = 5'd5; ex_rt = 5'd5;
      step("fwd_wb_only",    5'b11111, 4'b0000, 2'b10, 2'b10, 1'b0, 2'd2, 2'd1);
      mem_regwrite = 1; mem_write_reg = 5'd7; ex_rs = 5'd7; ex_rt = 5'd5;
      step("fwd_mixed",      5'b11111, 4'b0000, 2'b01, 2'b10, 1'b0, 2'd2, 2'd1);

      // Halt with forwarding inputs still active.
      wb_halt = 1;
      step("halt_enter",     5'b00000, 4'b0000, 2'b01, 2'b10, 1'b0, 2'd2, 2'd1);
      branch_taken = 1;
      step("halt_ign_branch",5'b00000, 4'b0000, 2'b01, 2'b10, 1'b1, 2'd2, 2'd1);
      branch_taken = 0; go = 1;
      step("halt_go_rise",   5'b00000, 4'b0000, 2'b01, 2'b10, 1'b1, 2'd2, 2'd1);
      step("resume_cycle",   5'b11111, 4'b0001, 2'b01, 2'b10, 1'b0, 2'd2, 2'd1);
      wb_halt = 0;
      step("run_go_held",    5'b11111, 4'b0000, 2'b01, 2'b10, 1'b0, 2'd2, 2'd1);

      idle();
      wb_halt = 1;
      step("halt2_enter",    5'b00000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd2, 2'd1);
      wb_halt = 0; go = 1;
      step("halt2_go",       5'b00000, 4'b0000, 2'b00, 2'b00, 1'b1, 2'd2, 2'd1);
      load_use_rs8();
      step("resume_loaduse", 5'b00111, 4'b0101, 2'b00, 2'b00, 1'b0, 2'd2, 2'd1);
      step("loaduse_sat_a",  5'b00111, 4'b0100, 2'b00, 2'b00, 1'b0, 2'd3, 2'd1);
      step("loaduse_sat_b",  5'b00111, 4'b0100, 2'b00, 2'b00, 1'b0, 2'd3, 2'd1);
      idle();
      step("stall_sticks",   5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd3, 2'd1);

      // Asynchronous reset while halted.
      wb_halt = 1;
      step("halt3_enter",    5'b00000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd3, 2'd1);
      step("halt3_hold",     5'b00000, 4'b0000, 2'b00, 2'b00, 1'b1, 2'd3, 2'd1);
      idle();
      rst_n = 1'b0;
      step("reset_in_halt",  5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0);
      rst_n = 1'b1;
      step("run_after_rst",  5'b11111, 4'b0000, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0);
      load_use_rs8();
      step("loaduse_post_rst", 5'b00111, 4'b0100, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0);
      idle();

      // Bounded drain of the scoreboard.
      repeat (4) @(posedge clk);
      n_checks++;
      if (q_exp.size() == 0)
         n_pass++;
      else
         $display("FAIL drain: got %0d pending expected 0 pending", q_exp.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
